// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, alu_op bit positions,
// the decoded ID->EXE bundle layout and the divider state encoding.
package exe_stage_pkg;

   localparam int DS_TO_ES_BUS_WD = 146;
   localparam int ES_TO_MS_BUS_WD = 71;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;
   localparam int ALU_MULT = 12;
   localparam int ALU_MULTU = 13;
   localparam int ALU_DIV  = 14;
   localparam int ALU_DIVU = 15;
   localparam int ALU_MFHI = 16;
   localparam int ALU_MFLO = 17;
   localparam int ALU_MTHI = 18;
   localparam int ALU_MTLO = 19;

   // Field order matches the flat ds_to_es_bus, MSB first.
   typedef struct packed {
      logic [21:0] alu_op;
      logic        load_op;
      logic        src1_is_sa;
      logic        src1_is_pc;
      logic        src2_is_imm;
      logic        src2_is_8;
      logic        gr_we;
      logic        mem_we;
      logic [4:0]  dest;
      logic [15:0] imm;
      logic [31:0] rs_value;
      logic [31:0] rt_value;
      logic [31:0] pc;
   } ds_bus_t;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_iter.sv
// 32-step restoring divider on operand magnitudes with sign fixup; result is
// held in DONE until ack, then the unit returns to IDLE.
module div_iter
   import exe_stage_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ack,
   input  logic        signed_op,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        busy,
   output logic        done,
   output logic [31:0] q,
   output logic [31:0] r
);

   div_state_e  r_state;
   div_state_e  w_state_nxt;
   logic [4:0]  r_cnt;
   logic [31:0] r_quo;
   logic [31:0] r_rem;
   logic [31:0] r_div;
   logic [31:0] r_dvd;
   logic        r_q_neg;
   logic        r_r_neg;
   logic        r_y_zero;

   logic [31:0] w_xa;
   logic [31:0] w_ya;
   logic [32:0] w_rem_sh;
   logic [32:0] w_diff;

   assign w_xa = (signed_op && x[31]) ? (32'd0 - x) : x;
   assign w_ya = (signed_op && y[31]) ? (32'd0 - y) : y;

   // r_quo shifts the dividend out at the top while quotient bits enter below.
   assign w_rem_sh = {r_rem, r_quo[31]};
   assign w_diff   = w_rem_sh - {1'b0, r_div};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DIV_IDLE: if (start) w_state_nxt = DIV_BUSY;
         DIV_BUSY: if (r_cnt == 5'd31) w_state_nxt = DIV_DONE;
         DIV_DONE: if (ack) w_state_nxt = DIV_IDLE;
         default:  w_state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= DIV_IDLE;
         r_cnt    <= 5'd0;
         r_quo    <= 32'd0;
         r_rem    <= 32'd0;
         r_div    <= 32'd0;
         r_dvd    <= 32'd0;
         r_q_neg  <= 1'b0;
         r_r_neg  <= 1'b0;
         r_y_zero <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == DIV_IDLE && start) begin
            r_cnt    <= 5'd0;
            r_quo    <= w_xa;
            r_rem    <= 32'd0;
            r_div    <= w_ya;
            r_dvd    <= x;
            r_q_neg  <= signed_op & (x[31] ^ y[31]);
            r_r_neg  <= signed_op & x[31];
            r_y_zero <= (y == 32'd0);
         end else if (r_state == DIV_BUSY) begin
            r_cnt <= r_cnt + 5'd1;
            if (!w_diff[32]) begin
               r_rem <= w_diff[31:0];
               r_quo <= {r_quo[30:0], 1'b1};
            end else begin
               r_rem <= w_rem_sh[31:0];
               r_quo <= {r_quo[30:0], 1'b0};
            end
         end
      end
   end

   // Divide by zero: all-ones quotient, remainder is the original dividend.
   assign q = r_y_zero ? 32'hffff_ffff : (r_q_neg ? (32'd0 - r_quo) : r_quo);
   assign r = r_y_zero ? r_dvd : (r_r_neg ? (32'd0 - r_rem) : r_rem);

   assign busy = (r_state == DIV_BUSY);
   assign done = (r_state == DIV_DONE);

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: registers the ID bundle, runs the ALU, multiply, divide
// and HI/LO, issues data-SRAM requests and forwards the result bundle to MEM.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ms_allowin,
   output logic                       es_allowin,
   input  logic                       ds_to_es_valid,
   input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
   output logic                       es_to_ms_valid,
   output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic [4:0]                 exe_dst_reg,
   output logic                       data_sram_en,
   output logic [3:0]                 data_sram_wen,
   output logic [31:0]                data_sram_addr,
   output logic [31:0]                data_sram_wdata
);

   logic        r_es_valid;
   ds_bus_t     r_bus;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [21:0] w_op;
   logic        w_is_div;
   logic        w_is_mul;
   logic        w_ready_go;
   logic        w_fire;
   logic        w_div_busy;
   logic        w_div_done;
   logic [31:0] w_div_q;
   logic [31:0] w_div_r;
   logic        w_zext;
   logic [31:0] w_src1;
   logic [31:0] w_src2;
   logic [63:0] w_mul_a;
   logic [63:0] w_mul_b;
   logic [63:0] w_prod;
   logic [31:0] w_alu_result;
   logic        w_unused;

   assign w_op     = r_bus.alu_op;
   assign w_is_div = w_op[ALU_DIV] | w_op[ALU_DIVU];
   assign w_is_mul = w_op[ALU_MULT] | w_op[ALU_MULTU];
   assign w_unused = ^{w_op[21:20], w_div_busy};

   assign w_ready_go     = w_is_div ? w_div_done : 1'b1;
   assign es_to_ms_valid = r_es_valid && w_ready_go;
   assign es_allowin     = !r_es_valid || (w_ready_go && ms_allowin);
   assign w_fire         = es_to_ms_valid && ms_allowin;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_es_valid <= 1'b0;
         r_bus      <= '0;
      end else begin
         if (es_allowin) r_es_valid <= ds_to_es_valid;
         if (ds_to_es_valid && es_allowin) r_bus <= ds_bus_t'(ds_to_es_bus);
      end
   end

   div_iter u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (r_es_valid && w_is_div),
      .ack       (w_fire),
      .signed_op (w_op[ALU_DIV]),
      .x         (r_bus.rs_value),
      .y         (r_bus.rt_value),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .q         (w_div_q),
      .r         (w_div_r)
   );

   // andi/ori/xori take a zero-extended immediate; everything else sign-extends.
   assign w_zext = w_op[ALU_AND] | w_op[ALU_OR] | w_op[ALU_XOR];
   assign w_src1 = r_bus.src1_is_sa ? {27'd0, r_bus.imm[10:6]} :
                   r_bus.src1_is_pc ? r_bus.pc : r_bus.rs_value;
   assign w_src2 = r_bus.src2_is_8   ? 32'd8 :
                   r_bus.src2_is_imm ? (w_zext ? {16'd0, r_bus.imm} : {{16{r_bus.imm[15]}}, r_bus.imm}) :
                   r_bus.rt_value;

   // One 64-bit multiplier; operands are sign- or zero-extended first.
   assign w_mul_a = w_op[ALU_MULTU] ? {32'd0, r_bus.rs_value} : {{32{r_bus.rs_value[31]}}, r_bus.rs_value};
   assign w_mul_b = w_op[ALU_MULTU] ? {32'd0, r_bus.rt_value} : {{32{r_bus.rt_value[31]}}, r_bus.rt_value};
   assign w_prod  = w_mul_a * w_mul_b;

   always_comb begin
      w_alu_result = 32'd0;
      if (w_op[ALU_ADD])  w_alu_result = w_alu_result | (w_src1 + w_src2);
      if (w_op[ALU_SUB])  w_alu_result = w_alu_result | (w_src1 - w_src2);
      if (w_op[ALU_SLT])  w_alu_result = w_alu_result | {31'd0, $signed(w_src1) < $signed(w_src2)};
      if (w_op[ALU_SLTU]) w_alu_result = w_alu_result | {31'd0, w_src1 < w_src2};
      if (w_op[ALU_AND])  w_alu_result = w_alu_result | (w_src1 & w_src2);
      if (w_op[ALU_NOR])  w_alu_result = w_alu_result | ~(w_src1 | w_src2);
      if (w_op[ALU_OR])   w_alu_result = w_alu_result | (w_src1 | w_src2);
      if (w_op[ALU_XOR])  w_alu_result = w_alu_result | (w_src1 ^ w_src2);
      if (w_op[ALU_SLL])  w_alu_result = w_alu_result | (w_src2 << w_src1[4:0]);
      if (w_op[ALU_SRL])  w_alu_result = w_alu_result | (w_src2 >> w_src1[4:0]);
      if (w_op[ALU_SRA])  w_alu_result = w_alu_result | 32'($signed(w_src2) >>> w_src1[4:0]);
      if (w_op[ALU_LUI])  w_alu_result = w_alu_result | {w_src2[15:0], 16'd0};
      if (w_op[ALU_MFHI]) w_alu_result = w_alu_result | r_hi;
      if (w_op[ALU_MFLO]) w_alu_result = w_alu_result | r_lo;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_fire) begin
         if (w_is_mul) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
         end
         if (w_is_div) begin
            r_hi <= w_div_r;
            r_lo <= w_div_q;
         end
         if (w_op[ALU_MTHI]) r_hi <= r_bus.rs_value;
         if (w_op[ALU_MTLO]) r_lo <= r_bus.rs_value;
      end
   end

   assign es_to_ms_bus = {r_bus.load_op, r_bus.gr_we, r_bus.dest, w_alu_result, r_bus.pc};
   assign exe_dst_reg  = (r_es_valid && r_bus.gr_we) ? r_bus.dest : 5'd0;

   assign data_sram_en    = r_es_valid && (r_bus.load_op || r_bus.mem_we);
   assign data_sram_wen   = (r_es_valid && r_bus.mem_we) ? 4'hf : 4'h0;
   assign data_sram_addr  = w_alu_result;
   assign data_sram_wdata = r_bus.rt_value;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, SRAM requests, mult/div and HI/LO,
// backpressure and reset during a divide.
module tb_exe_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         ms_allowin;
   logic         es_allowin;
   logic         ds_to_es_valid;
   logic [145:0] ds_to_es_bus;
   logic         es_to_ms_valid;
   logic [70:0]  es_to_ms_bus;
   logic [4:0]   exe_dst_reg;
   logic         data_sram_en;
   logic [3:0]   data_sram_wen;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [6:0] F_LOAD = 7'b1000000;
   localparam logic [6:0] F_SA   = 7'b0100000;
   localparam logic [6:0] F_PC   = 7'b0010000;
   localparam logic [6:0] F_IMM  = 7'b0001000;
   localparam logic [6:0] F_8    = 7'b0000100;
   localparam logic [6:0] F_WE   = 7'b0000010;
   localparam logic [6:0] F_MEM  = 7'b0000001;

   exe_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ms_allowin      (ms_allowin),
      .es_allowin      (es_allowin),
      .ds_to_es_valid  (ds_to_es_valid),
      .ds_to_es_bus    (ds_to_es_bus),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .exe_dst_reg     (exe_dst_reg),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata)
   );

   always #5 clk = ~clk;

   function automatic logic [145:0] mk(input int op, input logic [6:0] fl, input logic [4:0] dest,
                                       input logic [15:0] imm, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [31:0] pc);
      logic [21:0] a;
      a = 22'd1 << op;
      return {a, fl, dest, imm, rs, rt, pc};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one bundle; on return it sits in EXE and outputs have settled.
   task automatic issue(input logic [145:0] b);
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = b;
      tick();
      ds_to_es_valid = 1'b0;
   endtask

   task automatic alu(input string tag, input logic [145:0] b, input logic [31:0] exp);
      issue(b);
      check(tag, es_to_ms_bus[63:32], exp);
   endtask

   task automatic wait_div(input string tag);
      int n = 0;
      check({tag, "_allowin"}, {31'd0, es_allowin}, 32'd0);
      while (es_to_ms_valid !== 1'b1 && n < 100) begin
         n++;
         tick();
      end
      check({tag, "_cycles"}, n, 32'd33);
   endtask

   initial begin
      reset          = 1'b1;
      ms_allowin     = 1'b1;
      ds_to_es_valid = 1'b0;
      ds_to_es_bus   = '0;
      repeat (2) tick();
      check("rst_valid",   {31'd0, es_to_ms_valid}, 32'd0);
      check("rst_allowin", {31'd0, es_allowin}, 32'd1);
      check("rst_dst",     {27'd0, exe_dst_reg}, 32'd0);
      check("rst_en",      {31'd0, data_sram_en}, 32'd0);
      check("rst_wen",     {28'd0, data_sram_wen}, 32'd0);
      reset = 1'b0;

      issue(mk(0, F_WE, 5'd3, 16'h0, 32'd5, 32'hffff_ffff, 32'h100));
      check("addu_valid", {31'd0, es_to_ms_valid}, 32'd1);
      check("addu_res",   es_to_ms_bus[63:32], 32'd4);
      check("addu_dst",   {27'd0, exe_dst_reg}, 32'd3);
      check("addu_busdst", {27'd0, es_to_ms_bus[68:64]}, 32'd3);
      check("addu_pc",    es_to_ms_bus[31:0], 32'h100);
      check("addu_en",    {31'd0, data_sram_en}, 32'd0);

      alu("ori",   mk(6, F_WE | F_IMM, 5'd4, 16'h8000, 32'd0, 32'd0, 32'h104), 32'h0000_8000);
      alu("addiu", mk(0, F_WE | F_IMM, 5'd4, 16'h8000, 32'd0, 32'd0, 32'h108), 32'hffff_8000);

      issue(mk(0, F_IMM | F_MEM, 5'd0, 16'h4, 32'h1000, 32'hdead_beef, 32'h10c));
      check("sw_en",    {31'd0, data_sram_en}, 32'd1);
      check("sw_wen",   {28'd0, data_sram_wen}, 32'hf);
      check("sw_addr",  data_sram_addr, 32'h1004);
      check("sw_wdata", data_sram_wdata, 32'hdead_beef);
      check("sw_dst",   {27'd0, exe_dst_reg}, 32'd0);

      issue(mk(0, F_LOAD | F_WE | F_IMM, 5'd8, 16'hfffc, 32'h1000, 32'd0, 32'h110));
      check("lw_en",   {31'd0, data_sram_en}, 32'd1);
      check("lw_wen",  {28'd0, data_sram_wen}, 32'd0);
      check("lw_addr", data_sram_addr, 32'h0ffc);
      check("lw_rfm",  {31'd0, es_to_ms_bus[70]}, 32'd1);

      alu("subu", mk(1,  F_WE, 5'd1, 16'h0, 32'd3, 32'd5, 32'h114), 32'hffff_fffe);
      alu("slt",  mk(2,  F_WE, 5'd1, 16'h0, 32'hffff_ffff, 32'd1, 32'h118), 32'd1);
      alu("sltu", mk(3,  F_WE, 5'd1, 16'h0, 32'hffff_ffff, 32'd1, 32'h11c), 32'd0);
      alu("and",  mk(4,  F_WE, 5'd1, 16'h0, 32'h0000_f0f0, 32'h0000_ff00, 32'h120), 32'h0000_f000);
      alu("nor",  mk(5,  F_WE, 5'd1, 16'h0, 32'd0, 32'd0, 32'h124), 32'hffff_ffff);
      alu("xor",  mk(7,  F_WE, 5'd1, 16'h0, 32'h0000_00ff, 32'h0000_000f, 32'h128), 32'h0000_00f0);
      alu("sll",  mk(8,  F_WE | F_SA, 5'd1, 16'h0100, 32'd0, 32'd1, 32'h12c), 32'h0000_0010);
      alu("srl",  mk(9,  F_WE | F_SA, 5'd1, 16'h0100, 32'd0, 32'h8000_0000, 32'h130), 32'h0800_0000);
      alu("sra",  mk(10, F_WE | F_SA, 5'd1, 16'h0100, 32'd0, 32'h8000_0000, 32'h134), 32'hf800_0000);
      alu("lui",  mk(11, F_WE | F_IMM, 5'd1, 16'h1234, 32'd0, 32'd0, 32'h138), 32'h1234_0000);
      alu("pc8",  mk(0,  F_WE | F_PC | F_8, 5'd31, 16'h0, 32'd0, 32'd0, 32'h200), 32'h0000_0208);

      issue(mk(12, 7'd0, 5'd0, 16'h0, 32'hffff_ffff, 32'd2, 32'h204));
      alu("mult_hi",  mk(16, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h208), 32'hffff_ffff);
      alu("mult_lo",  mk(17, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h20c), 32'hffff_fffe);
      issue(mk(13, 7'd0, 5'd0, 16'h0, 32'hffff_ffff, 32'd2, 32'h210));
      alu("multu_hi", mk(16, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h214), 32'h0000_0001);
      alu("multu_lo", mk(17, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h218), 32'hffff_fffe);

      issue(mk(14, 7'd0, 5'd0, 16'h0, 32'hffff_fff9, 32'd2, 32'h300));
      wait_div("div_m7_2");
      alu("div_lo", mk(17, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h304), 32'hffff_fffd);
      alu("div_hi", mk(16, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h308), 32'hffff_ffff);

      issue(mk(14, 7'd0, 5'd0, 16'h0, 32'd7, 32'hffff_fffe, 32'h30c));
      wait_div("div_7_m2");
      alu("div2_lo", mk(17, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h310), 32'hffff_fffd);
      alu("div2_hi", mk(16, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h314), 32'h0000_0001);

      issue(mk(15, 7'd0, 5'd0, 16'h0, 32'd100, 32'd7, 32'h318));
      wait_div("divu_100_7");
      issue(mk(15, 7'd0, 5'd0, 16'h0, 32'd7, 32'd0, 32'h31c));
      wait_div("divu_7_0");
      alu("divz_lo", mk(17, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h320), 32'hffff_ffff);
      alu("divz_hi", mk(16, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h324), 32'h0000_0007);

      tick();
      ms_allowin = 1'b0;
      issue(mk(18, 7'd0, 5'd0, 16'h0, 32'h55, 32'd0, 32'h400));
      ds_to_es_valid = 1'b1;
      ds_to_es_bus   = mk(16, F_WE, 5'd9, 16'h0, 32'd0, 32'd0, 32'h404);
      for (int i = 0; i < 5; i++) begin
         check("stall_allowin", {31'd0, es_allowin}, 32'd0);
         check("stall_valid",   {31'd0, es_to_ms_valid}, 32'd1);
         check("stall_pc",      es_to_ms_bus[31:0], 32'h400);
         check("stall_hi",      dut.r_hi, 32'h0000_0007);
         tick();
      end
      ms_allowin = 1'b1;
      tick();
      ds_to_es_valid = 1'b0;
      check("mthi_pc", es_to_ms_bus[31:0], 32'h404);
      check("mthi_hi", es_to_ms_bus[63:32], 32'h0000_0055);

      issue(mk(14, 7'd0, 5'd0, 16'h0, 32'd9, 32'd2, 32'h500));
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstdiv_valid",   {31'd0, es_to_ms_valid}, 32'd0);
      check("rstdiv_allowin", {31'd0, es_allowin}, 32'd1);
      alu("rst_hi", mk(16, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h504), 32'd0);
      issue(mk(15, 7'd0, 5'd0, 16'h0, 32'd9, 32'd2, 32'h508));
      wait_div("divu_9_2");
      alu("divu9_lo", mk(17, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h50c), 32'd4);
      alu("divu9_hi", mk(16, F_WE, 5'd2, 16'h0, 32'd0, 32'd0, 32'h510), 32'd1);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
